// File: rtl/cic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cic_ctrl_pkg
//
// Shared definitions for the CIC decimator rate controller:
//   - ctrl_state_t   : controller FSM state encoding
//   - rate_is_valid  : checks a requested ratio against the decimator's
//                      maximum ratio (1 <= rate <= max_rate, unsigned)
//   - max3           : helper used to size the shared state counter
// ---------------------------------------------------------------------------
package cic_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT_FLUSH,
        IDLE,
        WAIT_BOUNDARY,
        FLUSH,
        APPLY,
        SETTLE
    } ctrl_state_t;

    // The rate is passed zero-extended to 64 bits so that one function serves
    // every RATE_DW up to 64; the compare is unsigned throughout.
    function automatic logic rate_is_valid(input logic [63:0] rate,
                                           input int unsigned max_rate);
        return (rate != 64'd0) && (rate <= 64'(max_rate));
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// ---------------------------------------------------------------------------
// cic_rate_ctrl
//
// Changes the decimation ratio of a CIC decimator without producing corrupt
// output samples. A new ratio is only applied at an output boundary: the
// controller waits for the decimator's output strobe (or a timeout), flushes
// the decimator with a synchronous reset, loads the new ratio with a
// single-cycle pulse, then blanks the output until the filter has settled.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   s_axis_cfg_tdata    requested decimation ratio
//   s_axis_cfg_tvalid   request valid
//   s_axis_cfg_tready   request ready (high only while idle)
//   dec_out_tvalid      decimator output strobe (monitored)
//   m_axis_rate_tdata   ratio to decimator rate port
//   m_axis_rate_tvalid  single-cycle rate-load pulse
//   cic_reset_n         active-low synchronous flush to the decimator
//   blank               high while decimator output is not trustworthy
//   current_rate        last applied ratio
//   cfg_error           one-cycle pulse on a rejected request
//
// All outputs are registered and are a pure function of the registered state
// (plus the rate registers), so they change only on clock edges.
// ---------------------------------------------------------------------------
module cic_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned RATE_DW          = 32,
    parameter int unsigned CIC_R            = 10,
    parameter int unsigned FLUSH_CYCLES     = 4,
    parameter int unsigned SETTLE_OUTPUTS   = 7,
    parameter int unsigned BOUNDARY_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
    input  logic               s_axis_cfg_tvalid,
    output logic               s_axis_cfg_tready,
    input  logic               dec_out_tvalid,
    output logic [RATE_DW-1:0] m_axis_rate_tdata,
    output logic               m_axis_rate_tvalid,
    output logic               cic_reset_n,
    output logic               blank,
    output logic [RATE_DW-1:0] current_rate,
    output logic               cfg_error
);

    localparam int unsigned CNT_MAX = max3(FLUSH_CYCLES, SETTLE_OUTPUTS, BOUNDARY_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FLUSH  = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_SETTLE = CNT_W'(SETTLE_OUTPUTS);
    localparam logic [CNT_W-1:0]   CNT_TMO    = CNT_W'(BOUNDARY_TIMEOUT);
    localparam logic [RATE_DW-1:0] RATE_MAX   = RATE_DW'(CIC_R);

    ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RATE_DW-1:0] target_q, target_d;
    logic [RATE_DW-1:0] rate_d;
    logic               cfg_error_d;
    logic               cic_reset_n_d;
    logic               blank_d;
    logic               tready_d;
    logic               rate_tvalid_d;
    logic [RATE_DW-1:0] rate_tdata_d;
    logic               req_fire;
    logic               req_ok;

    // A request is taken whenever the registered ready is high, which only
    // happens in IDLE.
    assign req_fire = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign req_ok   = rate_is_valid(64'(s_axis_cfg_tdata), CIC_R);

    // Next-state logic. The one counter is reloaded on every state entry and
    // counts down to 1; a state that lasts N cycles (or N events) is left on
    // the edge where the counter reads 1.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        target_d    = target_q;
        rate_d      = current_rate;
        cfg_error_d = 1'b0;

        case (state_q)
            INIT_FLUSH, FLUSH: begin
                if (count_q == CNT_ONE) begin
                    state_d = APPLY;
                    count_d = CNT_ONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end

            IDLE: begin
                if (req_fire) begin
                    if (!req_ok) begin
                        cfg_error_d = 1'b1;
                    end else if (s_axis_cfg_tdata != current_rate) begin
                        target_d = s_axis_cfg_tdata;
                        state_d  = WAIT_BOUNDARY;
                        count_d  = CNT_TMO;
                    end
                end
            end

            WAIT_BOUNDARY: begin
                // Flushing right after an output strobe loses no sample that
                // was already in flight to the consumer.
                if (dec_out_tvalid || (count_q == CNT_ONE)) begin
                    state_d = FLUSH;
                    count_d = CNT_FLUSH;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end

            APPLY: begin
                state_d = SETTLE;
                count_d = CNT_SETTLE;
                rate_d  = target_q;
            end

            SETTLE: begin
                if (dec_out_tvalid) begin
                    if (count_q == CNT_ONE) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = INIT_FLUSH;
                count_d = CNT_FLUSH;
            end
        endcase
    end

    // Output values derived from the state being entered, so the registered
    // outputs line up cycle-for-cycle with the registered state.
    always_comb begin
        cic_reset_n_d = !((state_d == INIT_FLUSH) || (state_d == FLUSH));
        blank_d       = (state_d != IDLE) && (state_d != WAIT_BOUNDARY);
        tready_d      = (state_d == IDLE);
        rate_tvalid_d = (state_d == APPLY);
        rate_tdata_d  = (state_d == APPLY) ? target_d : rate_d;
    end

    // State, counter, rate registers and registered outputs. Reset lands in
    // INIT_FLUSH with the maximum ratio as target, so the decimator is always
    // brought up through a full flush/apply/settle sequence and any pending
    // request is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= INIT_FLUSH;
            count_q            <= CNT_FLUSH;
            target_q           <= RATE_MAX;
            current_rate       <= RATE_MAX;
            cic_reset_n        <= 1'b0;
            blank              <= 1'b1;
            s_axis_cfg_tready  <= 1'b0;
            m_axis_rate_tvalid <= 1'b0;
            m_axis_rate_tdata  <= RATE_MAX;
            cfg_error          <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            target_q           <= target_d;
            current_rate       <= rate_d;
            cic_reset_n        <= cic_reset_n_d;
            blank              <= blank_d;
            s_axis_cfg_tready  <= tready_d;
            m_axis_rate_tvalid <= rate_tvalid_d;
            m_axis_rate_tdata  <= rate_tdata_d;
            cfg_error          <= cfg_error_d;
        end
    end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cic_rate_ctrl
//
// Directed bench for cic_rate_ctrl with CIC_R=10, FLUSH_CYCLES=4,
// SETTLE_OUTPUTS=7, BOUNDARY_TIMEOUT=64. Single-cycle request outcomes are
// table driven; flush/apply/settle sequences are hand written. A negedge
// monitor counts flush cycles and rate-load pulses.
// ---------------------------------------------------------------------------
module tb_cic_rate_ctrl;

    localparam int SETTLE = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axis_cfg_tdata;
    logic        s_axis_cfg_tvalid;
    logic        s_axis_cfg_tready;
    logic        dec_out_tvalid;
    logic [31:0] m_axis_rate_tdata;
    logic        m_axis_rate_tvalid;
    logic        cic_reset_n;
    logic        blank;
    logic [31:0] current_rate;
    logic        cfg_error;

    int checks = 0;
    int errors = 0;

    int          low_cycles     = 0;
    int          rate_pulses    = 0;
    int          overlap_cycles = 0;
    logic [31:0] last_pulse_data = '0;
    int          base_low;
    int          base_pulses;

    typedef struct {
        logic [31:0] req_data;
        logic        exp_err;
        logic [31:0] exp_rate;
    } vec_t;

    vec_t vecs[5];

    cic_rate_ctrl #(
        .RATE_DW          (32),
        .CIC_R            (10),
        .FLUSH_CYCLES     (4),
        .SETTLE_OUTPUTS   (7),
        .BOUNDARY_TIMEOUT (64)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .s_axis_cfg_tdata   (s_axis_cfg_tdata),
        .s_axis_cfg_tvalid  (s_axis_cfg_tvalid),
        .s_axis_cfg_tready  (s_axis_cfg_tready),
        .dec_out_tvalid     (dec_out_tvalid),
        .m_axis_rate_tdata  (m_axis_rate_tdata),
        .m_axis_rate_tvalid (m_axis_rate_tvalid),
        .cic_reset_n        (cic_reset_n),
        .blank              (blank),
        .current_rate       (current_rate),
        .cfg_error          (cfg_error)
    );

    always #5 clk = ~clk;

    // One sample per clock cycle, taken mid-cycle, of the flush line and the
    // rate-load strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (!cic_reset_n) low_cycles <= low_cycles + 1;
            if (m_axis_rate_tvalid) begin
                rate_pulses     <= rate_pulses + 1;
                last_pulse_data <= m_axis_rate_tdata;
                if (!cic_reset_n) overlap_cycles <= overlap_cycles + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs, then advance past one rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic valid, input logic dec);
        s_axis_cfg_tdata  = data;
        s_axis_cfg_tvalid = valid;
        dec_out_tvalid    = dec;
        step();
    endtask

    task automatic request(input logic [31:0] r);
        applyStimulus(r, 1'b1, 1'b0);
        s_axis_cfg_tvalid = 1'b0;
    endtask

    // Deliver n decimator output strobes, assuming SETTLE was just entered.
    task automatic pulseDec(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(32'd0, 1'b0, 1'b1);
            checkOutput("settle_blank", 32'(blank), (i + 1 >= SETTLE) ? 32'd0 : 32'd1);
            checkOutput("settle_tready", 32'(s_axis_cfg_tready), (i + 1 >= SETTLE) ? 32'd1 : 32'd0);
            applyStimulus(32'd0, 1'b0, 1'b0);
        end
    endtask

    // Four flush edges bring the controller into APPLY; one more into SETTLE.
    task automatic flushAndApply(input logic [31:0] exp_rate, input logic [31:0] old_rate);
        for (int i = 0; i < 4; i++) applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("apply_tvalid", 32'(m_axis_rate_tvalid), 32'd1);
        checkOutput("apply_tdata", m_axis_rate_tdata, exp_rate);
        checkOutput("apply_reset_n", 32'(cic_reset_n), 32'd1);
        checkOutput("apply_old_rate", current_rate, old_rate);
        applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("settle_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
        checkOutput("settle_rate", current_rate, exp_rate);
        checkOutput("settle_tdata", m_axis_rate_tdata, exp_rate);
    endtask

    initial begin
        vecs[0] = '{req_data: 32'd0,          exp_err: 1'b1, exp_rate: 32'd10};
        vecs[1] = '{req_data: 32'd11,         exp_err: 1'b1, exp_rate: 32'd10};
        vecs[2] = '{req_data: 32'd10,         exp_err: 1'b0, exp_rate: 32'd10};
        vecs[3] = '{req_data: 32'hFFFF_FFFF,  exp_err: 1'b1, exp_rate: 32'd10};
        vecs[4] = '{req_data: 32'h8000_000A,  exp_err: 1'b1, exp_rate: 32'd10};

        reset             = 1'b1;
        s_axis_cfg_tdata  = '0;
        s_axis_cfg_tvalid = 1'b0;
        dec_out_tvalid    = 1'b0;
        step();
        step();

        checkOutput("rst_reset_n", 32'(cic_reset_n), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'd1);
        checkOutput("rst_tready", 32'(s_axis_cfg_tready), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
        checkOutput("rst_cfg_error", 32'(cfg_error), 32'd0);
        checkOutput("rst_rate", current_rate, 32'd10);
        checkOutput("rst_tdata", m_axis_rate_tdata, 32'd10);

        // Power-up: strobes during the flush must be ignored.
        $display("[TB] init flush sequence");
        base_low    = low_cycles;
        base_pulses = rate_pulses;
        reset       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd0, 1'b0, 1'b1);
            checkOutput("init_flush_reset_n", 32'(cic_reset_n), 32'd0);
        end
        s_axis_cfg_tdata  = '0;
        dec_out_tvalid    = 1'b0;
        step();
        checkOutput("init_apply_tvalid", 32'(m_axis_rate_tvalid), 32'd1);
        checkOutput("init_apply_tdata", m_axis_rate_tdata, 32'd10);
        applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("init_settle_blank", 32'(blank), 32'd1);
        pulseDec(SETTLE);
        checkOutput("init_low_cycles", 32'(low_cycles - base_low), 32'd4);
        checkOutput("init_pulses", 32'(rate_pulses - base_pulses), 32'd1);
        checkOutput("init_pulse_data", last_pulse_data, 32'd10);

        // Requests that finish in IDLE: rejects and same-rate acknowledgements.
        $display("[TB] idle request table");
        base_low    = low_cycles;
        base_pulses = rate_pulses;
        for (int i = 0; i < 5; i++) begin
            request(vecs[i].req_data);
            checkOutput("tbl_cfg_error", 32'(cfg_error), 32'(vecs[i].exp_err));
            checkOutput("tbl_tready", 32'(s_axis_cfg_tready), 32'd1);
            checkOutput("tbl_reset_n", 32'(cic_reset_n), 32'd1);
            checkOutput("tbl_rate", current_rate, vecs[i].exp_rate);
            applyStimulus(32'd0, 1'b0, 1'b0);
            checkOutput("tbl_cfg_error_clear", 32'(cfg_error), 32'd0);
        end
        checkOutput("tbl_low_cycles", 32'(low_cycles - base_low), 32'd0);
        checkOutput("tbl_pulses", 32'(rate_pulses - base_pulses), 32'd0);

        // Rate 5 with an output boundary three cycles after the request.
        $display("[TB] change to 5 on boundary");
        base_low    = low_cycles;
        base_pulses = rate_pulses;
        request(32'd5);
        checkOutput("r5_tready", 32'(s_axis_cfg_tready), 32'd0);
        checkOutput("r5_wait_reset_n", 32'(cic_reset_n), 32'd1);
        applyStimulus(32'd0, 1'b0, 1'b0);
        applyStimulus(32'd0, 1'b0, 1'b1);
        checkOutput("r5_flush_reset_n", 32'(cic_reset_n), 32'd0);
        checkOutput("r5_flush_blank", 32'(blank), 32'd1);
        flushAndApply(32'd5, 32'd10);
        pulseDec(SETTLE);
        checkOutput("r5_low_cycles", 32'(low_cycles - base_low), 32'd4);
        checkOutput("r5_pulses", 32'(rate_pulses - base_pulses), 32'd1);
        checkOutput("r5_pulse_data", last_pulse_data, 32'd5);

        // Rate 4 with no boundary: timeout after 64 cycles in WAIT_BOUNDARY.
        $display("[TB] change to 4 on timeout");
        request(32'd4);
        for (int i = 0; i < 63; i++) applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("r4_wait63_reset_n", 32'(cic_reset_n), 32'd1);
        checkOutput("r4_wait63_tready", 32'(s_axis_cfg_tready), 32'd0);
        applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("r4_wait64_reset_n", 32'(cic_reset_n), 32'd0);
        flushAndApply(32'd4, 32'd5);
        pulseDec(SETTLE);
        checkOutput("r4_rate", current_rate, 32'd4);

        // Rate 3, then reset in the middle of SETTLE.
        $display("[TB] reset during settle");
        request(32'd3);
        applyStimulus(32'd0, 1'b0, 1'b1);
        flushAndApply(32'd3, 32'd4);
        pulseDec(3);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_rate", current_rate, 32'd10);
        checkOutput("mid_rst_tready", 32'(s_axis_cfg_tready), 32'd0);
        checkOutput("mid_rst_reset_n", 32'(cic_reset_n), 32'd0);
        checkOutput("mid_rst_blank", 32'(blank), 32'd1);
        step();
        step();
        base_low    = low_cycles;
        base_pulses = rate_pulses;
        reset       = 1'b0;
        flushAndApply(32'd10, 32'd10);
        pulseDec(SETTLE);
        checkOutput("rr_low_cycles", 32'(low_cycles - base_low), 32'd4);
        checkOutput("rr_pulses", 32'(rate_pulses - base_pulses), 32'd1);
        checkOutput("rr_pulse_data", last_pulse_data, 32'd10);
        checkOutput("rr_rate", current_rate, 32'd10);

        checkOutput("pulse_during_flush", 32'(overlap_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
